bin2bcd_seq: RTL and testbench

Parametrised, sequential binary-to-BCD converter with a per-digit seven-segment decoder. It uses double-dabble (shift-and-add-3), processing one input bit per clock behind a start/busy/done handshake. It sits between the cipher datapath's byte/word taps and the board display, and generalises the fixed 8-bit, 3-digit combinational converter to any width and digit count.

---
 rtl/bin2bcd_pkg.sv | 54 +++++
 rtl/bcd_seg7.sv | 25 ++
 rtl/bin2bcd_seq.sv | 139 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_pkg
//  Description : Shared definitions for the sequential binary-to-BCD converter.
//                Contains the FSM state enum, the seven-segment patterns, the
//                blank pattern and the digit-count helper used by the
//                elaboration check.
//  Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Active-low {g,f,e,d,c,b,a}; all segments off.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Index n holds the active-low pattern for decimal digit n.
   localparam logic [9:0][6:0] SEG_PATTERN = {
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   // Smallest digit count d such that 10^d > 2^width - 1.
   function automatic int min_digits(input int width);
      longint unsigned maxv;
      longint unsigned pow;
      int              d;
      maxv = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
      pow  = 64'd10;
      d    = 1;
      while ((pow <= maxv) && (d < 19)) begin
         pow = pow * 64'd10;
         d   = d + 1;
      end
      // 10^19 is the largest power of ten that fits; one more digit covers the rest.
      if (pow <= maxv) begin
         d = d + 1;
      end
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg7
//  Description : Single-digit BCD to active-low seven-segment decoder.
//                Nibbles above 9 drive the blank pattern.
//  Ports       : bcd_i [3:0] - BCD digit
//                seg_o [6:0] - active-low segments {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg7
   import bin2bcd_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (bcd_i <= 4'd9) begin
         seg_o = SEG_PATTERN[bcd_i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter, one input
//                bit per clock, with a start/busy/done handshake and a
//                per-digit seven-segment decode of the held result.
//  Config      : BIN2BCD_LZB_EN - when defined, digits above the most
//                significant non-zero digit are blanked (digit 0 never is).
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                start    - conversion request, sampled only when idle
//                data_in  - unsigned binary value [WIDTH-1:0]
//                busy     - high while converting
//                done     - one-cycle pulse when bcd_out updates
//                bcd_out  - packed BCD result, units in [3:0]
//                seg_out  - active-low segments per digit, units in [6:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    data_in,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic [7*DIGITS-1:0] seg_out
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (DIGITS < min_digits(WIDTH)) begin : g_digit_check
      $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
             DIGITS, WIDTH, min_digits(WIDTH));
   end

   state_e              state_q;
   logic                busy_q;
   logic                done_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [4*DIGITS-1:0] scratch_q;
   logic [WIDTH-1:0]    bin_q;

   logic [4*DIGITS-1:0] adj_d;
   logic [4*DIGITS-1:0] scratch_d;
   logic [WIDTH-1:0]    bin_d;
   logic [7*DIGITS-1:0] seg_raw_d;
   logic [DIGITS-1:0]   lit_d;

   // Add-3 correction per digit; no carry crosses digit boundaries.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj_d[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                (scratch_q[4*gi +: 4] + 4'd3) :
                                 scratch_q[4*gi +: 4];
   end

   // The top bit of the corrected scratch falls off the end of the shift.
   assign {scratch_d, bin_d} = {adj_d, bin_q} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         scratch_q <= '0;
         bin_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bin_q     <= data_in;
                  scratch_q <= '0;
                  cnt_q     <= CNT_INIT;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scratch_q <= scratch_d;
               bin_q     <= bin_d;
               cnt_q     <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  bcd_q   <= scratch_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_q;

   for (genvar gd = 0; gd < DIGITS; gd++) begin : g_seg
      bcd_seg7 u_seg (
         .bcd_i (bcd_q[4*gd +: 4]),
         .seg_o (seg_raw_d[7*gd +: 7])
      );
   end

`ifdef BIN2BCD_LZB_EN
   // A digit stays lit once any digit at or above it is non-zero; units always lit.
   always_comb begin
      logic seen;
      seen  = 1'b0;
      lit_d = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen     = seen | (bcd_q[4*i +: 4] != 4'd0);
         lit_d[i] = seen | (i == 0);
      end
   end
`else
   assign lit_d = '1;
`endif

   for (genvar go = 0; go < DIGITS; go++) begin : g_out
      assign seg_out[7*go +: 7] = lit_d[go] ? seg_raw_d[7*go +: 7] : SEG_BLANK;
   end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Self-checking bench for bin2bcd_seq: an 8-bit/3-digit and a
//                16-bit/5-digit instance driven with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start8 = 1'b0;
   logic [7:0]  din8 = '0;
   logic        busy8;
   logic        done8;
   logic [11:0] bcd8;
   logic [20:0] seg8;
   logic        start16 = 1'b0;
   logic [15:0] din16 = '0;
   logic        busy16;
   logic        done16;
   logic [19:0] bcd16;
   logic [34:0] seg16;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start8),
      .data_in (din8),
      .busy    (busy8),
      .done    (done8),
      .bcd_out (bcd8),
      .seg_out (seg8)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start16),
      .data_in (din16),
      .busy    (busy16),
      .done    (done16),
      .bcd_out (bcd16),
      .seg_out (seg16)
   );

   typedef struct packed {
      logic [7:0]  din;
      logic [11:0] bcd;
   } vec8_t;

   typedef struct packed {
      logic [15:0] din;
      logic [19:0] bcd;
   } vec16_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [34:0] exp_seg(input logic [19:0] b, input int nd);
      logic [34:0] s;
      logic        seen;
      s    = '0;
      seen = 1'b0;
      for (int i = nd - 1; i >= 0; i--) begin
         seen       = seen | (b[4*i +: 4] != 4'd0);
         s[7*i +: 7] = seg_of(b[4*i +: 4]);
`ifdef BIN2BCD_LZB_EN
         if (!seen && (i != 0)) s[7*i +: 7] = 7'b1111111;
`endif
      end
      return s;
   endfunction

   task automatic run8(input logic [7:0] din, input logic [11:0] exp_bcd);
      int lat;
      int busy_bad;
      @(negedge clk);
      start8 = 1'b1;
      din8   = din;
      @(negedge clk);
      start8 = 1'b0;
      din8   = ~din;   // must not disturb the captured value
      lat      = 0;
      busy_bad = 0;
      while (!done8 && (lat < 40)) begin
         if (busy8 !== 1'b1) busy_bad++;
         @(negedge clk);
         lat++;
      end
      chk($sformatf("lat8_%0d", din), 64'(lat), 64'd8);
      chk($sformatf("busy8_run_%0d", din), 64'(busy_bad), 64'd0);
      chk($sformatf("busy8_end_%0d", din), 64'(busy8), 64'd0);
      chk($sformatf("bcd8_%0d", din), 64'(bcd8), 64'(exp_bcd));
      chk($sformatf("seg8_%0d", din), 64'(seg8), 64'(exp_seg({8'd0, exp_bcd}, 3)));
      @(negedge clk);
      chk($sformatf("done8_clear_%0d", din), 64'(done8), 64'd0);
   endtask

   task automatic run16(input logic [15:0] din, input logic [19:0] exp_bcd);
      int lat;
      @(negedge clk);
      start16 = 1'b1;
      din16   = din;
      @(negedge clk);
      start16 = 1'b0;
      din16   = ~din;
      lat = 0;
      while (!done16 && (lat < 60)) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("lat16_%0d", din), 64'(lat), 64'd16);
      chk($sformatf("bcd16_%0d", din), 64'(bcd16), 64'(exp_bcd));
      chk($sformatf("seg16_%0d", din), 64'(seg16), 64'(exp_seg(exp_bcd, 5)));
      @(negedge clk);
      chk($sformatf("done16_clear_%0d", din), 64'(done16), 64'd0);
   endtask

   initial begin
      vec8_t  v8 [8];
      vec16_t v16 [3];
      int     n;
      int     extra;

      v8[0] = '{din: 8'd255, bcd: 12'h255};
      v8[1] = '{din: 8'd0,   bcd: 12'h000};
      v8[2] = '{din: 8'd100, bcd: 12'h100};
      v8[3] = '{din: 8'd1,   bcd: 12'h001};
      v8[4] = '{din: 8'd99,  bcd: 12'h099};
      v8[5] = '{din: 8'd128, bcd: 12'h128};
      v8[6] = '{din: 8'd170, bcd: 12'h170};
      v8[7] = '{din: 8'd37,  bcd: 12'h037};

      v16[0] = '{din: 16'd65535, bcd: 20'h65535};
      v16[1] = '{din: 16'd1234,  bcd: 20'h01234};
      v16[2] = '{din: 16'd10000, bcd: 20'h10000};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_bcd", 64'(bcd8), 64'd0);
      chk("rst_seg", 64'(seg8), 64'(exp_seg(20'd0, 3)));
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run8(v8[i].din, v8[i].bcd);
      end
      // 255 again with hand-written segment digits 2/5/5
      run8(8'd255, 12'h255);
      chk("seg8_255_literal", 64'(seg8), 64'({7'b0100100, 7'b0010010, 7'b0010010}));

      // start held high: 9 then 42, one conversion per 9 cycles
      @(negedge clk);
      start8 = 1'b1;
      din8   = 8'd9;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done8 && (n < 40));
      chk("held_period1", 64'(n), 64'd9);
      chk("held_bcd9", 64'(bcd8), 64'h009);
      din8 = 8'd42;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done8 && (n < 40));
      chk("held_period2", 64'(n), 64'd9);
      chk("held_bcd42", 64'(bcd8), 64'h042);
      start8 = 1'b0;

      // Pulses while busy must not produce extra conversions
      @(negedge clk);
      start8 = 1'b1;
      din8   = 8'd7;
      @(negedge clk);
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         start8 = (c % 2 == 0) && (c < 6);
         din8   = 8'd200;
         @(negedge clk);
         if (done8) extra++;
      end
      start8 = 1'b0;
      chk("busy_pulses_dones", 64'(extra), 64'd1);
      chk("busy_pulses_bcd", 64'(bcd8), 64'h007);

      // Reset during cycle 4 of a conversion of 200
      @(negedge clk);
      start8 = 1'b1;
      din8   = 8'd200;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy8), 64'd0);
      chk("midrst_bcd", 64'(bcd8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done8 || busy8) extra++;
      end
      chk("midrst_quiet", 64'(extra), 64'd0);
      run8(8'd200, 12'h200);

      for (int i = 0; i < 3; i++) begin
         run16(v16[i].din, v16[i].bcd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
